// File: rtl/dmem_arbiter_64.sv
// dmem_arbiter_64: arbitrates fetch (f_) and memory-stage (m_) accesses to a
// shared 1024 x 64-bit data memory, with bound checking and fetch anti-starvation.
module dmem_arbiter_64 #(
    parameter logic [63:0] ADDR_LIMIT = 64'd1023,
    parameter int          MEM_LAT    = 2,
    parameter int          STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [63:0] f_rdata,
    output logic        f_err,
    input  logic        m_req,
    input  logic        m_we,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_gnt,
    output logic        m_valid,
    output logic [63:0] m_rdata,
    output logic        m_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        busy
);
    localparam logic [3:0] LAT_INIT  = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

    state_t      state, state_n;
    logic        owner, owner_n;          // 1 = memory stage owns the access
    logic        wr, wr_n;                // current access is a write
    logic [3:0]  lat_cnt, lat_n;
    logic [3:0]  starve_cnt, starve_n;

    logic        f_gnt_n, f_valid_n, f_err_n;
    logic        m_gnt_n, m_valid_n, m_err_n;
    logic [63:0] f_rdata_n, m_rdata_n;
    logic        mem_en_n, mem_we_n, busy_n;
    logic [9:0]  mem_addr_n;
    logic [63:0] mem_wdata_n;

    logic        pick_m, pick_f;
    logic [63:0] sel_addr;

    // Register all state and every output; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            wr         <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            f_gnt      <= 1'b0;
            f_valid    <= 1'b0;
            f_err      <= 1'b0;
            f_rdata    <= '0;
            m_gnt      <= 1'b0;
            m_valid    <= 1'b0;
            m_err      <= 1'b0;
            m_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            wr         <= wr_n;
            lat_cnt    <= lat_n;
            starve_cnt <= starve_n;
            f_gnt      <= f_gnt_n;
            f_valid    <= f_valid_n;
            f_err      <= f_err_n;
            f_rdata    <= f_rdata_n;
            m_gnt      <= m_gnt_n;
            m_valid    <= m_valid_n;
            m_err      <= m_err_n;
            m_rdata    <= m_rdata_n;
            mem_en     <= mem_en_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            busy       <= busy_n;
        end
    end

    // Next-state and next-output logic; pulses default low, address/data hold.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        wr_n        = wr;
        lat_n       = lat_cnt;
        starve_n    = starve_cnt;
        f_gnt_n     = 1'b0;
        f_valid_n   = 1'b0;
        f_err_n     = 1'b0;
        f_rdata_n   = '0;
        m_gnt_n     = 1'b0;
        m_valid_n   = 1'b0;
        m_err_n     = 1'b0;
        m_rdata_n   = '0;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        busy_n      = busy;

        // Memory stage is older and normally wins; a saturated starve count flips it.
        pick_m   = m_req && !(f_req && starve_cnt == STARVE_LM);
        pick_f   = f_req && !pick_m;
        sel_addr = pick_m ? m_addr : f_addr;

        case (state)
            IDLE: begin
                if (pick_m || pick_f) begin
                    owner_n = pick_m;
                    wr_n    = pick_m && m_we;
                    f_gnt_n = pick_f;
                    m_gnt_n = pick_m;
                    busy_n  = 1'b1;
                    if (pick_f)
                        starve_n = '0;
                    else if (f_req && starve_cnt < STARVE_LM)
                        starve_n = starve_cnt + 4'd1;
                    if (sel_addr > ADDR_LIMIT) begin
                        state_n = ERR;
                    end else begin
                        mem_en_n    = 1'b1;
                        mem_we_n    = pick_m && m_we;
                        mem_addr_n  = sel_addr[9:0];
                        mem_wdata_n = pick_m ? m_wdata : '0;
                        lat_n       = LAT_INIT;
                        state_n     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (lat_cnt == 4'd0) begin
                    if (owner) begin
                        m_valid_n = 1'b1;
                        m_rdata_n = wr ? '0 : mem_rdata;
                    end else begin
                        f_valid_n = 1'b1;
                        f_rdata_n = mem_rdata;
                    end
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    lat_n = lat_cnt - 4'd1;
                end
            end
            ERR: begin
                if (owner) begin
                    m_valid_n = 1'b1;
                    m_err_n   = 1'b1;
                end else begin
                    f_valid_n = 1'b1;
                    f_err_n   = 1'b1;
                end
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dmem_arbiter_64.sv
// Directed bench for dmem_arbiter_64 with a queue scoreboard and a valid monitor.
module tb_dmem_arbiter_64;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, m_req, m_we;
    logic [63:0] f_addr, m_addr, m_wdata;
    logic        f_gnt, f_valid, f_err, m_gnt, m_valid, m_err;
    logic [63:0] f_rdata, m_rdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    typedef struct packed {
        logic        owner;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] mem [0:1023];

    dmem_arbiter_64 dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
        .f_rdata(f_rdata), .f_err(f_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_valid(m_valid), .m_rdata(m_rdata), .m_err(m_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: samples the strobe, read data held until the next read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!reset && (f_valid || m_valid)) begin
            exp_t e;
            if (f_valid && m_valid) chk("both_valid", 1, 0);
            if (sb.size() == 0) begin
                chk("unexpected_valid", {f_valid, m_valid}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_owner", m_valid, e.owner);
                chk("sb_rdata", m_valid ? m_rdata : f_rdata, e.rdata);
                chk("sb_err",   m_valid ? m_err : f_err, e.err);
            end
        end
    end

    // Wait (bounded) for any grant; reports which requester got it.
    task automatic wait_gnt(output bit got_m);
        int n = 0;
        got_m = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(f_gnt || m_gnt) && n < 30);
        chk("gnt_seen", f_gnt || m_gnt, 1);
        if (f_gnt && m_gnt) chk("gnt_both", 1, 0);
        got_m = m_gnt;
    endtask

    // Wait (bounded) for any valid; returns edges since the grant edge.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!(f_valid || m_valid) && n < 30);
        chk("valid_seen", f_valid || m_valid, 1);
    endtask

    // Single access by one requester; drops req in the valid cycle.
    task automatic access(input bit is_m, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] exp_rd,
                          input bit exp_err);
        bit got_m;
        int n;
        sb.push_back('{owner: is_m, rdata: exp_rd, err: exp_err});
        if (is_m) begin
            m_req = 1; m_we = we; m_addr = addr; m_wdata = wdata;
        end else begin
            f_req = 1; f_addr = addr;
        end
        wait_gnt(got_m);
        chk("gnt_owner", got_m, is_m);
        chk("gnt_mem_en", mem_en, !exp_err);
        chk("gnt_busy", busy, 1);
        if (!exp_err) begin
            chk("gnt_mem_addr", mem_addr, addr[9:0]);
            chk("gnt_mem_we", mem_we, we);
            if (we) chk("gnt_mem_wdata", mem_wdata, wdata);
        end
        wait_valid(n);
        chk("latency", n, exp_err ? 1 : MEM_LAT + 1);
        chk("valid_busy", busy, 0);
        if (is_m) m_req = 0; else f_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit got_m;
        int n;
        bit exp_m [10];
        logic [9:0] exp_seq;
        for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
        mem[0] = 64'h55;
        mem[5] = 64'hDEAD_BEEF;
        mem_rdata = '0;
        reset = 1; f_req = 0; m_req = 0; m_we = 0;
        f_addr = 0; m_addr = 0; m_wdata = 0;
        #12;
        chk("rst_outputs", {f_gnt, f_valid, f_err, m_gnt, m_valid, m_err, mem_en, mem_we, busy}, 0);
        chk("rst_rdata", f_rdata | m_rdata | mem_wdata | 64'(mem_addr), 0);
        @(negedge clk); reset = 0;
        @(posedge clk); #1;

        // Fetch read of a preloaded word
        access(0, 0, 64'd5, 0, 64'hDEAD_BEEF, 0);
        // Memory-stage write then read back at the top legal address
        access(1, 1, 64'd1023, 64'h1234, 64'd0, 0);
        access(1, 0, 64'd1023, 0, 64'h1234, 0);
        // Out-of-range: error completion, memory untouched
        access(1, 1, 64'd1024, 64'hBAD, 64'd0, 1);
        access(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0, 1);
        access(0, 0, 64'd1024, 0, 64'd0, 1);
        access(1, 0, 64'd0, 0, 64'h55, 0);
        chk("mem0_untouched", mem[0], 64'h55);

        // Contention: both held; m wins 4, then f, repeatedly
        exp_seq = 10'b1111011110;  // bit 9 = first grant, 1 = m
        for (int i = 0; i < 10; i++) begin
            exp_m[i] = exp_seq[9 - i];
            sb.push_back('{owner: exp_m[i], rdata: exp_m[i] ? 64'h1234 : 64'hDEAD_BEEF, err: 1'b0});
        end
        f_addr = 5; m_addr = 1023; m_we = 0; f_req = 1; m_req = 1;
        for (int i = 0; i < 10; i++) begin
            wait_gnt(got_m);
            chk($sformatf("contend_gnt%0d", i), got_m, exp_m[i]);
            wait_valid(n);
        end
        f_req = 0; m_req = 0;
        @(posedge clk); #1;

        // Stuck request: req held through valid gives a second identical grant
        sb.push_back('{owner: 1'b0, rdata: 64'hDEAD_BEEF, err: 1'b0});
        sb.push_back('{owner: 1'b0, rdata: 64'hDEAD_BEEF, err: 1'b0});
        f_addr = 5; f_req = 1;
        wait_gnt(got_m);
        wait_valid(n);
        @(posedge clk); #1;
        chk("stuck_regnt", f_gnt, 1);
        chk("stuck_addr", mem_addr, 10'd5);
        wait_valid(n);
        f_req = 0;
        @(posedge clk); #1;

        // Reset in the middle of a fetch read
        f_addr = 5; f_req = 1;
        wait_gnt(got_m);
        @(posedge clk); #3;
        reset = 1;
        #1;
        chk("midrst_outputs", {f_gnt, f_valid, f_err, m_gnt, m_valid, m_err, mem_en, mem_we, busy}, 0);
        chk("midrst_addr", mem_addr, 0);
        f_req = 0;
        @(negedge clk); @(negedge clk); reset = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_valid", f_valid, 0);
        chk("midrst_idle", busy, 0);
        access(0, 0, 64'd5, 0, 64'hDEAD_BEEF, 0);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
